apb_regs_mode: RTL and testbench
================================

Name: apb_regs_mode

Overview:
APB4 register-file slave and successor to the flat RW/RO register bank. Each register has its own access mode: RW, RO, W1C (hardware-set status) or W1P (write-pulse command). The block adds programmable wait states and per-register write strobes. It sits between the peripheral APB demux and IP-level control/status logic.

Parameters:
NoApbRegs, 8, number of registers (>=1)
ApbAddrWidth, 12, width of req_i.paddr (>=3)
ApbDataWidth, 32, width of pwdata/prdata (1..32)
RegDataWidth, 32, register width, <= ApbDataWidth; reads zero-extended, upper write bits ignored
AddrOffset, 4, byte stride between registers (>=4); bytes 4..AddrOffset-1 of each slot are holes
RegMode, all 2'd0, logic [NoApbRegs-1:0][1:0]; 0=RW, 1=RO, 2=W1C, 3=W1P
WaitStates, 0, access-phase cycles with pready low before completion (0..15)
req_t, logic, APB4 request struct (paddr, pprot, psel, penable, pwrite, pwdata, pstrb)
resp_t, logic, APB4 response struct (pready, prdata, pslverr)

Ports:
pclk_i  in  1  clock
preset_i  in  1  reset, synchronous, active-high
req_i  in  req_t  APB4 request
resp_o  out  resp_t  APB4 response
base_addr_i  in  ApbAddrWidth  byte address of register 0
reg_init_i  in  [NoApbRegs][RegDataWidth]  reset value (RW/W1C); live read value (RO)
hw_set_i  in  [NoApbRegs][RegDataWidth]  per-bit set for W1C registers; ignored for other modes
reg_q_o  out  [NoApbRegs][RegDataWidth]  register contents (see modes)
wr_pulse_o  out  [NoApbRegs]  one-cycle strobe per completed error-free write

Behaviour:
- Only one clock and one reset exist: clock pclk_i; reset preset_i is synchronous and active-high. All state updates on the pclk_i rising edge.
- Reset, sampled at a rising edge with preset_i=1:
  - RW and W1C registers take reg_init_i.
  - W1P registers clear to 0.
  - The wait counter clears to 0 and wr_pulse_o clears to 0.
  - While preset_i=1, resp_o.pready=0 and no write commits.
- Reset mid-transfer: the transfer stalls. Counting restarts from 0 after release.
- Decode: off = paddr - base_addr_i; idx = off / AddrOffset.
  - Valid iff paddr >= base_addr_i, idx < NoApbRegs and (off % AddrOffset) < 4.
- Wait states: cnt_q counts cycles with psel&penable&!pready and saturates at WaitStates.
  - pready = psel & penable & (cnt_q == WaitStates) & !preset_i.
  - cnt_q returns to 0 on completion or whenever psel=0.
  - WaitStates=0 gives zero-wait completion in the first access cycle.
- Completion means the cycle in which pready=1. Writes commit only at completion, never in setup or wait cycles.
- pslverr=1 at completion if the decode is invalid, or if a write targets an RO register. The error is ignored with no state change.
- prdata:
  - Valid read: the zero-extended value per mode.
  - Otherwise: 32'h0BAD_B10C truncated to ApbDataWidth.
- Byte mask: mask bit i = pstrb[i/8].
- RW:
  - Write: q <= (q & ~mask) | (pwdata & mask).
  - Read returns q; reg_q_o = q.
- RO: read returns reg_init_i[idx] live; reg_q_o = reg_init_i.
- W1C: q <= (q & ~(pwdata & mask)) | hw_set_i, evaluated every cycle.
  - When a hardware set and a software clear hit the same bit in the same cycle, set wins.
  - Read returns q.
- W1P:
  - reg_q_o = pwdata & mask for exactly the cycle after completion, then 0.
  - Reads return 0.
- wr_pulse_o[idx] is high for 1 cycle, registered, in the cycle after an error-free write completion. This includes writes with pstrb=0 (data unchanged).
- Back-to-back transfers (a new setup immediately after completion) are supported with no bubble beyond the APB protocol.

Test Plan:
- Reset with reg_init_i[0]=32'h1234_5678, RW → after reset, read of base+0 returns 32'h1234_5678 with pslverr=0.
- WaitStates=2, write 32'hDEAD_BEEF with pstrb=4'b0011 to RW reg1 (init 0) → pready low for 2 access cycles, high on the 3rd; reg_q_o[1]=32'h0000_BEEF from the next cycle; wr_pulse_o[1] high for exactly 1 cycle.
- W1C reg2: hw_set_i[2]=32'h5 pulsed → read returns 32'h5. Write 32'h1 in the same cycle as hw_set_i[2]=32'h1 → value stays 32'h5. A later write of 32'h4 → 32'h1.
- Writes to an RO register, to a hole (AddrOffset=8, base+4), and to base+NoApbRegs*AddrOffset → each gives pslverr=1 and prdata 32'h0BAD_B10C on read; no register changes and no wr_pulse_o.
- W1P reg3: write 32'h0000_00A5 → reg_q_o[3]=32'hA5 for one cycle, then 0; a read returns 0.
- preset_i asserted during wait state 1 of a write → no pready and no commit; after release the master re-issues and the full wait count is applied.

Source files
------------

// File: rtl/apb_regs_mode.sv
// APB4 register-file slave with per-register access modes (RW, RO, W1C, W1P),
// programmable wait states and byte write strobes.
package apb_regs_mode_pkg;
    typedef struct packed {
        logic [11:0] paddr;
        logic [2:0]  pprot;
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
    } apb_req_t;

    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } apb_resp_t;
endpackage

module apb_regs_mode #(
    parameter int NoApbRegs = 8,
    parameter int ApbAddrWidth = 12,
    parameter int ApbDataWidth = 32,
    parameter int RegDataWidth = 32,
    parameter int AddrOffset = 4,
    parameter logic [NoApbRegs-1:0][1:0] RegMode = '0,
    parameter int WaitStates = 0,
    parameter type req_t = apb_regs_mode_pkg::apb_req_t,
    parameter type resp_t = apb_regs_mode_pkg::apb_resp_t
) (
    input  logic                                    pclk_i,
    input  logic                                    preset_i,
    input  req_t                                    req_i,
    output resp_t                                   resp_o,
    input  logic [ApbAddrWidth-1:0]                 base_addr_i,
    input  logic [NoApbRegs-1:0][RegDataWidth-1:0]  reg_init_i,
    input  logic [NoApbRegs-1:0][RegDataWidth-1:0]  hw_set_i,
    output logic [NoApbRegs-1:0][RegDataWidth-1:0]  reg_q_o,
    output logic [NoApbRegs-1:0]                    wr_pulse_o
);
    localparam int IdxWidth = (NoApbRegs > 1) ? $clog2(NoApbRegs) : 1;
    localparam logic [3:0] WaitCnt = 4'(WaitStates);
    localparam logic [31:0] ErrWord = 32'h0BAD_B10C;
    localparam logic [1:0] ModeRw = 2'd0;
    localparam logic [1:0] ModeRo = 2'd1;
    localparam logic [1:0] ModeW1c = 2'd2;
    localparam logic [1:0] ModeW1p = 2'd3;

    logic [ApbAddrWidth-1:0] off;
    logic [ApbAddrWidth-1:0] idx_full;
    logic [ApbAddrWidth-1:0] slot;
    logic [IdxWidth-1:0]     idx;
    logic                    addr_ok;
    logic [1:0]              mode_sel;
    logic [RegDataWidth-1:0] rd_val;
    logic [ApbDataWidth-1:0] mask;
    logic [RegDataWidth-1:0] wdata_m;
    logic [3:0]              cnt_q;
    logic                    access;
    logic                    pready;
    logic                    slverr;
    logic                    wr_ok;
    logic [NoApbRegs-1:0]    hit_vec;
    logic [NoApbRegs-1:0][RegDataWidth-1:0] q_all;
    logic                    unused_sink;

    assign off      = req_i.paddr - base_addr_i;
    assign idx_full = off / ApbAddrWidth'(AddrOffset);
    assign slot     = off % ApbAddrWidth'(AddrOffset);
    assign idx      = idx_full[IdxWidth-1:0];
    assign addr_ok  = (req_i.paddr >= base_addr_i)
                    && (idx_full < ApbAddrWidth'(NoApbRegs))
                    && (slot < ApbAddrWidth'(4));

    always_comb begin
        mode_sel = ModeRw;
        rd_val   = '0;
        hit_vec  = '0;
        for (int r = 0; r < NoApbRegs; r++) begin
            if (idx == IdxWidth'(r)) begin
                mode_sel   = RegMode[r];
                rd_val     = (RegMode[r] == ModeW1p) ? '0 : q_all[r];
                hit_vec[r] = wr_ok;
            end
        end
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < ApbDataWidth; i++) begin
            mask[i] = req_i.pstrb[i/8];
        end
    end

    assign wdata_m = req_i.pwdata[RegDataWidth-1:0] & mask[RegDataWidth-1:0];

    // Reset forces pready low so a stalled transfer can never complete mid-reset.
    assign access = req_i.psel & req_i.penable;
    assign pready = access & (cnt_q == WaitCnt) & ~preset_i;
    assign slverr = ~addr_ok | (req_i.pwrite & (mode_sel == ModeRo));
    assign wr_ok  = pready & req_i.pwrite & ~slverr;

    always_comb begin
        resp_o         = '0;
        resp_o.pready  = pready;
        resp_o.pslverr = pready & slverr;
        resp_o.prdata  = (addr_ok & ~req_i.pwrite) ? ApbDataWidth'(rd_val)
                                                   : ErrWord[ApbDataWidth-1:0];
    end

    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            cnt_q      <= '0;
            wr_pulse_o <= '0;
        end else begin
            wr_pulse_o <= hit_vec;
            if (!req_i.psel || pready) begin
                cnt_q <= '0;
            end else if (access && (cnt_q != WaitCnt)) begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    for (genvar r = 0; r < NoApbRegs; r++) begin : g_reg
        logic [RegDataWidth-1:0] q;

        if (RegMode[r] == ModeRo) begin : g_ro
            assign q = reg_init_i[r];
        end else if (RegMode[r] == ModeW1c) begin : g_w1c
            // Hardware set is OR-ed last so it wins over a same-cycle clear.
            always_ff @(posedge pclk_i) begin
                if (preset_i) begin
                    q <= reg_init_i[r];
                end else begin
                    q <= (q & ~(hit_vec[r] ? wdata_m : '0)) | hw_set_i[r];
                end
            end
        end else if (RegMode[r] == ModeW1p) begin : g_w1p
            always_ff @(posedge pclk_i) begin
                if (preset_i) begin
                    q <= '0;
                end else begin
                    q <= hit_vec[r] ? wdata_m : '0;
                end
            end
        end else begin : g_rw
            always_ff @(posedge pclk_i) begin
                if (preset_i) begin
                    q <= reg_init_i[r];
                end else if (hit_vec[r]) begin
                    q <= (q & ~mask[RegDataWidth-1:0]) | wdata_m;
                end
            end
        end

        assign q_all[r] = q;
    end

    assign reg_q_o = q_all;

    assign unused_sink = ^{req_i, mask, hw_set_i, reg_init_i};
endmodule

// File: tb/tb_apb_regs_mode.sv
// Scoreboard bench for apb_regs_mode: 8 regs, 8-byte stride, 2 wait states,
// reg2 W1C, reg3 W1P, reg4 RO, the rest RW.
module tb_apb_regs_mode;
    import apb_regs_mode_pkg::*;

    localparam int NRegs = 8;
    localparam logic [11:0] Base = 12'h100;
    localparam logic [31:0] BadWord = 32'h0BAD_B10C;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        chk_data;
        int          waits;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    apb_req_t  req;
    apb_resp_t resp;
    logic [NRegs-1:0][31:0] reg_init;
    logic [NRegs-1:0][31:0] hw_set;
    logic [NRegs-1:0][31:0] reg_q;
    logic [NRegs-1:0][31:0] q_pre;
    logic [NRegs-1:0]       wr_pulse;

    exp_t sb_q[$];
    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    apb_regs_mode #(
        .NoApbRegs (NRegs),
        .AddrOffset(8),
        .RegMode   (16'h01E0),
        .WaitStates(2)
    ) dut (
        .pclk_i     (clk),
        .preset_i   (rst),
        .req_i      (req),
        .resp_o     (resp),
        .base_addr_i(Base),
        .reg_init_i (reg_init),
        .hw_set_i   (hw_set),
        .reg_q_o    (reg_q),
        .wr_pulse_o (wr_pulse)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One full APB transfer; hw_cpl is driven on hw_set[2] during the completion cycle.
    task automatic do_xfer(input string tag, input logic [11:0] addr, input logic wr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           input logic [31:0] hw_cpl, input logic [31:0] exp_data,
                           input logic exp_err);
        exp_t e;
        int waits;
        e.data = exp_data;
        e.err = exp_err;
        e.chk_data = !wr;
        e.waits = 2;
        sb_q.push_back(e);
        @(posedge clk); #1;
        req.paddr = addr;
        req.pwrite = wr;
        req.pwdata = wdata;
        req.pstrb = strb;
        req.psel = 1'b1;
        req.penable = 1'b0;
        @(posedge clk); #1;
        req.penable = 1'b1;
        waits = 0;
        while (!resp.pready && waits < 20) begin
            @(posedge clk); #1;
            waits++;
        end
        e = sb_q.pop_front();
        check({tag, "_rdy"}, 32'(resp.pready), 32'd1);
        check({tag, "_waits"}, 32'(waits), 32'(e.waits));
        check({tag, "_err"}, 32'(resp.pslverr), 32'(e.err));
        if (e.chk_data) check({tag, "_data"}, resp.prdata, e.data);
        check({tag, "_prepulse"}, 32'(wr_pulse), 32'd0);
        q_pre = reg_q;
        hw_set[2] = hw_cpl;
        @(posedge clk); #1;
        hw_set[2] = '0;
        req.psel = 1'b0;
        req.penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req = '0;
        hw_set = '0;
        reg_init = '0;
        reg_init[0] = 32'h1234_5678;
        reg_init[4] = 32'hCAFE_F00D;
        reg_init[5] = 32'h0000_5005;

        repeat (2) @(posedge clk);
        #1;
        req.psel = 1'b1;
        req.penable = 1'b1;
        req.paddr = Base;
        check("rst_rdy", 32'(resp.pready), 32'd0);
        @(posedge clk); #1;
        check("rst_rdy2", 32'(resp.pready), 32'd0);
        rst = 1'b0;
        req = '0;
        check("rst_q0", reg_q[0], 32'h1234_5678);
        check("rst_q2", reg_q[2], 32'h0);
        check("rst_q3", reg_q[3], 32'h0);
        check("rst_pulse", 32'(wr_pulse), 32'h0);

        do_xfer("rd0", 12'h100, 1'b0, 32'h0, 4'h0, 32'h0, 32'h1234_5678, 1'b0);

        do_xfer("wr1", 12'h108, 1'b1, 32'hDEAD_BEEF, 4'b0011, 32'h0, 32'h0, 1'b0);
        check("wr1_pre", q_pre[1], 32'h0);
        check("wr1_q", reg_q[1], 32'h0000_BEEF);
        check("wr1_pulse", 32'(wr_pulse), 32'h02);
        @(posedge clk); #1;
        check("wr1_pulse_end", 32'(wr_pulse), 32'h0);
        do_xfer("rd1", 12'h108, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0000_BEEF, 1'b0);

        do_xfer("wr1_nostrb", 12'h108, 1'b1, 32'hFFFF_FFFF, 4'h0, 32'h0, 32'h0, 1'b0);
        check("nostrb_q", reg_q[1], 32'h0000_BEEF);
        check("nostrb_pulse", 32'(wr_pulse), 32'h02);

        @(posedge clk); #1;
        hw_set[2] = 32'h5;
        @(posedge clk); #1;
        hw_set[2] = '0;
        check("w1c_set", reg_q[2], 32'h5);
        do_xfer("rd2a", 12'h110, 1'b0, 32'h0, 4'h0, 32'h0, 32'h5, 1'b0);
        do_xfer("w1c_race", 12'h110, 1'b1, 32'h1, 4'hF, 32'h1, 32'h0, 1'b0);
        check("w1c_race_q", reg_q[2], 32'h5);
        check("w1c_race_pulse", 32'(wr_pulse), 32'h04);
        do_xfer("w1c_clr", 12'h110, 1'b1, 32'h4, 4'hF, 32'h0, 32'h0, 1'b0);
        check("w1c_clr_q", reg_q[2], 32'h1);
        do_xfer("rd2b", 12'h110, 1'b0, 32'h0, 4'h0, 32'h0, 32'h1, 1'b0);

        do_xfer("wr_ro", 12'h120, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, 32'h0, 1'b1);
        check("wr_ro_q", reg_q[4], 32'hCAFE_F00D);
        check("wr_ro_pulse", 32'(wr_pulse), 32'h0);
        do_xfer("rd_ro", 12'h120, 1'b0, 32'h0, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b0);
        reg_init[4] = 32'h1234_0000;
        do_xfer("rd_ro_live", 12'h120, 1'b0, 32'h0, 4'h0, 32'h0, 32'h1234_0000, 1'b0);

        do_xfer("wr_hole", 12'h104, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, 32'h0, 1'b1);
        check("wr_hole_q0", reg_q[0], 32'h1234_5678);
        check("wr_hole_pulse", 32'(wr_pulse), 32'h0);
        do_xfer("rd_hole", 12'h104, 1'b0, 32'h0, 4'h0, 32'h0, BadWord, 1'b1);
        do_xfer("wr_oor", 12'h140, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, 32'h0, 1'b1);
        check("wr_oor_pulse", 32'(wr_pulse), 32'h0);
        check("wr_oor_q1", reg_q[1], 32'h0000_BEEF);
        do_xfer("rd_oor", 12'h140, 1'b0, 32'h0, 4'h0, 32'h0, BadWord, 1'b1);
        do_xfer("rd_below", 12'h0F8, 1'b0, 32'h0, 4'h0, 32'h0, BadWord, 1'b1);

        do_xfer("wr_w1p", 12'h118, 1'b1, 32'h0000_00A5, 4'hF, 32'h0, 32'h0, 1'b0);
        check("w1p_pre", q_pre[3], 32'h0);
        check("w1p_q", reg_q[3], 32'h0000_00A5);
        check("w1p_pulse", 32'(wr_pulse), 32'h08);
        @(posedge clk); #1;
        check("w1p_q_end", reg_q[3], 32'h0);
        do_xfer("rd_w1p", 12'h118, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0);

        // Reset lands in the second access cycle of a write to reg5.
        @(posedge clk); #1;
        req.paddr = 12'h128;
        req.pwrite = 1'b1;
        req.pwdata = 32'h55AA_55AA;
        req.pstrb = 4'hF;
        req.psel = 1'b1;
        req.penable = 1'b0;
        @(posedge clk); #1;
        req.penable = 1'b1;
        check("mr_a0", 32'(resp.pready), 32'd0);
        @(posedge clk); #1;
        check("mr_a1", 32'(resp.pready), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("mr_hold", 32'(resp.pready), 32'd0);
        end
        check("mr_q5", reg_q[5], 32'h0000_5005);
        check("mr_pulse", 32'(wr_pulse), 32'h0);
        rst = 1'b0;
        req.psel = 1'b0;
        req.penable = 1'b0;
        do_xfer("mr_reissue", 12'h128, 1'b1, 32'h55AA_55AA, 4'hF, 32'h0, 32'h0, 1'b0);
        check("mr_q5_new", reg_q[5], 32'h55AA_55AA);
        check("mr_pulse_new", 32'(wr_pulse), 32'h20);
        check("mr_q1_reload", reg_q[1], 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
